token_to_number: RTL and testbench

//  Numeric-literal stage directly downstream of the tokenizer, taking the place of uart_tx as the

---
 rtl/token_to_number.sv | 187 ++++++++++++++++++
 tb/tb_token_to_number.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/token_to_number.sv
// Numeric-literal stage: pulls token bytes from the tokenizer and converts
// each whitespace-delimited token to a WIDTH-bit cell (Forth >NUMBER style).
module token_to_number #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_BASE = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [7:0]       i_data,
    input  logic             i_ready,
    input  logic [5:0]       i_base,
    output logic             o_next,
    output logic [WIDTH-1:0] o_value,
    output logic             o_valid,
    output logic             o_nan,
    output logic             o_overflow
);

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        SIGN,
        ACCUM,
        SKIP,
        EMIT
    } state_t;

    state_t           state;
    logic [5:0]       base_q;
    logic [WIDTH-1:0] acc;
    logic             neg;
    logic             ovf;
    logic             emit_num;
    logic             next_q;
    logic             valid_q;
    logic             nan_q;

    logic             accept;
    logic             is_delim;
    logic             is_minus;
    logic             is_prefix;
    logic [5:0]       prefix_base;
    logic [5:0]       digit;
    logic [5:0]       base_in;
    logic [5:0]       cur_base;
    logic             dig_ok;
    logic [WIDTH+6:0] prod;

    function automatic logic [5:0] digit_of(input logic [7:0] c);
        logic [5:0] d;
        d = 6'h3f;
        if (c >= 8'h30 && c <= 8'h39)
            d = 6'(c - 8'h30);
        else if (c >= 8'h41 && c <= 8'h5a)
            d = 6'(c - 8'h37);
        else if (c >= 8'h61 && c <= 8'h7a)
            d = 6'(c - 8'h57);
        return d;
    endfunction

    // Pulses are only visible on enabled cycles so a frozen stage
    // never advances the tokenizer or double-reports a token.
    assign o_next  = next_q & i_en;
    assign o_valid = valid_q & i_en;
    assign o_nan   = nan_q & i_en;

    always_comb begin
        is_delim = (i_data == 8'h00) || (i_data == 8'h09) ||
                   (i_data == 8'h0a) || (i_data == 8'h0d) ||
                   (i_data == 8'h20);
        is_minus    = (i_data == 8'h2d);
        is_prefix   = 1'b1;
        prefix_base = 6'd10;
        unique case (1'b1)
            (i_data == 8'h24): prefix_base = 6'd16;
            (i_data == 8'h23): prefix_base = 6'd10;
            (i_data == 8'h25): prefix_base = 6'd2;
            default:           is_prefix   = 1'b0;
        endcase
        digit    = digit_of(i_data);
        base_in  = (i_base >= 6'd2 && i_base <= 6'd36) ? i_base
                                                       : 6'(DEFAULT_BASE);
        cur_base = (state == IDLE) ? base_in : base_q;
        dig_ok   = digit < cur_base;
        prod     = (WIDTH+7)'(acc) * (WIDTH+7)'(base_q) + (WIDTH+7)'(digit);
        accept   = i_en & i_ready & ~next_q & (state != EMIT);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            base_q     <= 6'(DEFAULT_BASE);
            acc        <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            emit_num   <= 1'b0;
            next_q     <= 1'b0;
            valid_q    <= 1'b0;
            nan_q      <= 1'b0;
            o_value    <= '0;
            o_overflow <= 1'b0;
        end else if (i_en) begin
            next_q  <= accept;
            valid_q <= 1'b0;
            nan_q   <= 1'b0;
            if (state == EMIT) begin
                if (emit_num) begin
                    o_value    <= neg ? (~acc + 1'b1) : acc;
                    valid_q    <= 1'b1;
                    o_overflow <= ovf;
                end else begin
                    nan_q      <= 1'b1;
                    o_overflow <= 1'b0;
                end
                acc   <= '0;
                neg   <= 1'b0;
                ovf   <= 1'b0;
                state <= IDLE;
            end else if (accept) begin
                unique case (state)
                    IDLE: begin
                        base_q <= base_in;
                        if (is_delim) begin
                            state <= IDLE;
                        end else if (is_prefix) begin
                            base_q <= prefix_base;
                            state  <= PREFIX;
                        end else if (is_minus) begin
                            neg   <= 1'b1;
                            state <= SIGN;
                        end else if (dig_ok) begin
                            acc   <= WIDTH'(digit);
                            state <= ACCUM;
                        end else begin
                            state <= SKIP;
                        end
                    end
                    PREFIX: begin
                        if (is_minus) begin
                            neg   <= 1'b1;
                            state <= SIGN;
                        end else if (dig_ok) begin
                            acc   <= WIDTH'(digit);
                            state <= ACCUM;
                        end else if (is_delim) begin
                            emit_num <= 1'b0;
                            state    <= EMIT;
                        end else begin
                            state <= SKIP;
                        end
                    end
                    SIGN: begin
                        if (dig_ok) begin
                            acc   <= WIDTH'(digit);
                            state <= ACCUM;
                        end else if (is_delim) begin
                            emit_num <= 1'b0;
                            state    <= EMIT;
                        end else begin
                            state <= SKIP;
                        end
                    end
                    ACCUM: begin
                        if (dig_ok) begin
                            acc <= prod[WIDTH-1:0];
                            ovf <= ovf | (|prod[WIDTH+6:WIDTH]);
                        end else if (is_delim) begin
                            emit_num <= 1'b1;
                            state    <= EMIT;
                        end else begin
                            state <= SKIP;
                        end
                    end
                    SKIP: begin
                        if (is_delim) begin
                            emit_num <= 1'b0;
                            state    <= EMIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_token_to_number.sv
// Bench for token_to_number: streaming string-level reference model with a
// per-cycle output compare, plus hand-computed literal checks.
module tb_token_to_number;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        ready = 1'b0;
    logic [5:0]  base = 6'd10;
    logic        nxt;
    logic [15:0] value;
    logic        valid;
    logic        nan;
    logic        overflow;

    token_to_number #(.WIDTH(16), .DEFAULT_BASE(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data),
        .i_ready(ready), .i_base(base), .o_next(nxt), .o_value(value),
        .o_valid(valid), .o_nan(nan), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_nan;
        int unsigned val;
        bit          ov;
    } exp_t;

    exp_t        expq[$];
    byte         pq[$];
    int          pbase;
    int unsigned last_val = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_next   = 0;
    int n_valid  = 0;
    int n_nan    = 0;
    int n_sent   = 0;
    int unsigned seen_val = 0;
    int unsigned seen_ovf = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int digval(input byte c);
        if (c >= "0" && c <= "9") return c - "0";
        if (c >= "A" && c <= "Z") return c - "A" + 10;
        if (c >= "a" && c <= "z") return c - "a" + 10;
        return 99;
    endfunction

    function automatic bit is_delim(input byte c);
        return c == 8'h00 || c == 8'h09 || c == 8'h0a ||
               c == 8'h0d || c == 8'h20;
    endfunction

    // Evaluate the complete pending token as Forth >NUMBER would.
    function automatic void eval_token();
        exp_t   e;
        int     b;
        int     i;
        int     d;
        bit     ng;
        longint a;
        b  = (pbase >= 2 && pbase <= 36) ? pbase : 10;
        i  = 0;
        ng = 0;
        a  = 0;
        e.is_nan = 0;
        e.ov     = 0;
        if (pq[0] == 8'h24) begin b = 16; i = 1; end
        else if (pq[0] == 8'h23) begin b = 10; i = 1; end
        else if (pq[0] == 8'h25) begin b = 2; i = 1; end
        if (i < pq.size() && pq[i] == 8'h2d) begin ng = 1; i++; end
        if (i >= pq.size()) e.is_nan = 1;
        for (; i < pq.size(); i++) begin
            d = digval(pq[i]);
            if (d >= b) e.is_nan = 1;
            else begin
                a = a * b + d;
                if (a >= 65536) begin
                    e.ov = 1;
                    a = a % 65536;
                end
            end
        end
        if (e.is_nan) begin
            e.val = last_val;
            e.ov  = 0;
        end else begin
            e.val    = ng ? int'((65536 - a) % 65536) : int'(a);
            last_val = e.val;
        end
        expq.push_back(e);
    endfunction

    function automatic void model_feed(input byte c);
        if (is_delim(c)) begin
            if (pq.size() != 0) eval_token();
            pq.delete();
        end else begin
            if (pq.size() == 0) pbase = int'(base);
            pq.push_back(c);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (nxt) n_next++;
            if (valid && nan) chk("valid_and_nan", 1, 0);
            if (valid || nan) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("kind_nan", nan, e.is_nan);
                    chk("value", value, e.val);
                    chk("overflow", overflow, e.ov);
                end
                if (valid) n_valid++;
                if (nan) n_nan++;
                seen_val = value;
                seen_ovf = overflow;
            end
        end
    end

    task automatic send_byte(input byte c);
        bit ok;
        model_feed(c);
        data  = c;
        ready = 1'b1;
        ok    = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (nxt) begin
                ok = 1;
                break;
            end
        end
        ready = 1'b0;
        n_sent++;
        if (!ok) chk("next_timeout", 0, 1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expq.delete();
        pq.delete();
        last_val = 0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    int v0, x0, e0;

    initial begin
        do_reset();
        chk("rst_next", nxt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_nan", nan, 0);
        chk("rst_value", value, 0);
        chk("rst_ovf", overflow, 0);

        base = 6'd10;
        e0 = n_next; v0 = n_valid;
        send_str("123 ");
        chk("123_value", seen_val, 123);
        chk("123_ovf", seen_ovf, 0);
        chk("123_pulses", n_valid - v0, 1);
        chk("123_next", n_next - e0, 4);

        send_str("$-1F\r");
        chk("hexneg_value", seen_val, 16'hFFE1);
        x0 = n_nan;
        send_str("-$1F ");
        chk("signfirst_nan", n_nan - x0, 1);
        chk("signfirst_hold", value, 16'hFFE1);

        x0 = n_nan;
        send_str("12x4");
        chk("skip_early", n_nan - x0, 0);
        send_str(" ");
        chk("skip_late", n_nan - x0, 1);

        e0 = n_next; v0 = n_valid; x0 = n_nan;
        send_str("  \t ");
        chk("ws_next", n_next - e0, 4);
        chk("ws_pulses", (n_valid - v0) + (n_nan - x0), 0);

        send_str("65537 ");
        chk("wrap_value", seen_val, 1);
        chk("wrap_ovf", seen_ovf, 1);
        send_str("%101 ");
        chk("bin_value", seen_val, 5);

        base = 6'd16;
        send_str("ff ");
        chk("hex_value", seen_val, 255);
        base = 6'd40;
        x0 = n_nan;
        send_str("ff ");
        chk("badbase_nan", n_nan - x0, 1);
        base = 6'd10;
        x0 = n_nan;
        send_str("-");
        send_str(" ");
        chk("lone_minus", n_nan - x0, 1);
        send_str("7fFf 0 -32768 ");
        chk("neg_min", seen_val, 16'h8000);

        send_str("12");
        do_reset();
        chk("mid_rst_value", value, 0);
        send_str("7 ");
        chk("after_rst", seen_val, 7);

        e0 = n_next;
        en    = 1'b0;
        data  = "5";
        ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (nxt) chk("en_low_next", 1, 0);
        end
        chk("en_low_count", n_next - e0, 0);
        en = 1'b1;
        send_str("5 ");
        chk("en_resume", seen_val, 5);

        repeat (5) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        chk("next_total", n_next, n_sent);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
